idma_axi_read_burst_gen: RTL

IDMA_AXI_READ_BURST_GEN -- requirements
Module: idma_axi_read_burst_gen

---
 rtl/idma_axi_read_burst_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/idma_axi_read_burst_gen.sv
// Splits a 1D transfer into AXI read bursts that respect the 4 KiB page rule and the beat limit.
// Each burst is forked onto the AR channel and the read datapath request channel.
module idma_axi_read_burst_gen #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned TFLenWidth = 32,
  parameter int unsigned MaxBeats   = 256,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned OffW      = $clog2(StrbWidth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  req_src_addr_i,
  input  logic [AddrWidth-1:0]  req_dst_addr_i,
  input  logic [TFLenWidth-1:0] req_length_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [AddrWidth-1:0]  ar_addr_o,
  output logic [7:0]            ar_len_o,
  output logic [2:0]            ar_size_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [OffW-1:0]       rdp_offset_o,
  output logic [OffW-1:0]       rdp_tailer_o,
  output logic [OffW-1:0]       rdp_shift_o,
  output logic                  rdp_valid_o,
  input  logic                  rdp_ready_i,
  output logic                  busy_o
);

  // Byte-count arithmetic width: wide enough for the length and for both burst limits.
  localparam int unsigned LimW = $clog2(MaxBeats * StrbWidth + 4096) + 1;
  localparam int unsigned BW   = (TFLenWidth > LimW) ? TFLenWidth : LimW;

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                r_state, w_state_nxt;
  logic [AddrWidth-1:0]  r_cur_addr;
  logic [TFLenWidth-1:0] r_remaining;
  logic [OffW-1:0]       r_shift;
  logic                  r_ar_done, r_rdp_done;

  logic                  w_req_hs, w_ar_hs, w_rdp_hs, w_burst_done, w_last;
  logic [BW-1:0]         w_rem_ext, w_page_bytes, w_beat_bytes, w_bytes, w_span;
  logic [TFLenWidth-1:0] w_bytes_tf;
  logic [AddrWidth-1:0]  w_next_addr;

  assign w_rem_ext    = BW'(r_remaining);
  assign w_page_bytes = BW'(4096) - BW'(r_cur_addr[11:0]);
  assign w_beat_bytes = BW'(MaxBeats * StrbWidth) - BW'(r_cur_addr[OffW-1:0]);

  always_comb begin
    w_bytes = w_rem_ext;
    if (w_page_bytes < w_bytes) w_bytes = w_page_bytes;
    if (w_beat_bytes < w_bytes) w_bytes = w_beat_bytes;
  end

  assign w_bytes_tf  = TFLenWidth'(w_bytes);
  assign w_next_addr = r_cur_addr + AddrWidth'(w_bytes);
  // Index of the last byte touched, relative to the first beat's aligned base.
  assign w_span      = BW'(r_cur_addr[OffW-1:0]) + w_bytes - BW'(1);
  assign w_last      = (r_remaining == w_bytes_tf);

  assign req_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state == EMIT);
  assign w_req_hs    = req_valid_i & req_ready_o;

  assign ar_valid_o  = (r_state == EMIT) & ~r_ar_done;
  assign rdp_valid_o = (r_state == EMIT) & ~r_rdp_done;
  assign w_ar_hs     = ar_valid_o & ar_ready_i;
  assign w_rdp_hs    = rdp_valid_o & rdp_ready_i;
  assign w_burst_done = (r_ar_done | w_ar_hs) & (r_rdp_done | w_rdp_hs);

  assign ar_addr_o    = r_cur_addr;
  assign ar_len_o     = 8'(w_span >> OffW);
  assign ar_size_o    = 3'(OffW);
  assign rdp_offset_o = r_cur_addr[OffW-1:0];
  assign rdp_tailer_o = OffW'(AddrWidth'(0) - w_next_addr);
  assign rdp_shift_o  = r_shift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_req_hs && (req_length_i != '0)) w_state_nxt = EMIT;
      EMIT: if (w_burst_done && w_last)            w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_ar_done   <= 1'b0;
      r_rdp_done  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_req_hs) begin
        r_cur_addr  <= req_src_addr_i;
        r_remaining <= req_length_i;
        r_shift     <= OffW'(req_src_addr_i - req_dst_addr_i);
        r_ar_done   <= 1'b0;
        r_rdp_done  <= 1'b0;
      end
    end else if (w_burst_done) begin
      r_cur_addr  <= w_next_addr;
      r_remaining <= r_remaining - w_bytes_tf;
      r_ar_done   <= 1'b0;
      r_rdp_done  <= 1'b0;
    end else begin
      // Sticky per-channel flags keep an accepted side quiet until its partner completes.
      if (w_ar_hs)  r_ar_done  <= 1'b1;
      if (w_rdp_hs) r_rdp_done <= 1'b1;
    end
  end

endmodule
